// File: rtl/divider_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package divider_pkg;

  localparam int unsigned NUM_CH_DEF      = 3;
  localparam int unsigned CNT_W_DEF       = 24;
  localparam int unsigned DEFAULT_DIV_DEF = 2400000;

  // Ceiling log2, floored at 1 so a single channel still has a select bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: counter, active/pending divisor and registered tick/div_clk.
module divider_channel
  import divider_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic             i_wr_sel,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_wr_ready,
  output logic             o_tick,
  output logic             o_div_clk
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_flag;
  logic             r_tick;
  logic             r_div_clk;
  logic             w_xfer;
  logic             w_term;
  logic             w_apply;

  assign w_xfer  = i_wr_sel & ~r_pend_flag;
  assign w_term  = (r_cnt == r_div);
  // A pending divisor lands only when the current period is over or the channel is idle.
  assign w_apply = r_pend_flag & (~i_en | w_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_div       <= DIV_RST;
      r_pend_flag <= 1'b0;
      r_tick      <= 1'b0;
      r_div_clk   <= 1'b0;
    end else if (i_restart) begin
      r_cnt       <= '0;
      r_tick      <= 1'b0;
      r_div_clk   <= 1'b0;
      r_pend_flag <= 1'b0;
      if (w_xfer)
        r_div <= i_wr_div;
      else if (r_pend_flag)
        r_div <= r_pend_div;
    end else begin
      if (!i_en) begin
        r_cnt     <= '0;
        r_tick    <= 1'b0;
        r_div_clk <= 1'b0;
      end else if (w_term) begin
        r_cnt     <= '0;
        r_tick    <= 1'b1;
        r_div_clk <= ~r_div_clk;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end
      if (w_apply) begin
        r_div       <= r_pend_div;
        r_pend_flag <= 1'b0;
      end else if (w_xfer) begin
        r_pend_flag <= 1'b1;
      end
    end
  end

  // Pending value is plain data; its flag alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (w_xfer && !i_restart)
      r_pend_div <= i_wr_div;
  end

  assign o_wr_ready = ~r_pend_flag;
  assign o_tick     = r_tick;
  assign o_div_clk  = r_div_clk;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent programmable dividers sharing one clock, write port and restart.
module multi_channel_clock_divider
  import divider_pkg::*;
#(
  parameter int unsigned NUM_CH      = NUM_CH_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int unsigned CH_W        = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_clk
);

  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_ch_ready;
  logic              w_wr_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_sel[gi] = wr_valid & (wr_ch == CH_W'(gi));

    divider_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (ch_en[gi]),
      .i_restart  (sync_restart),
      .i_wr_sel   (w_sel[gi]),
      .i_wr_div   (wr_div),
      .o_wr_ready (w_ch_ready[gi]),
      .o_tick     (tick[gi]),
      .o_div_clk  (div_clk[gi])
    );
  end

  // Selects beyond the last channel are always ready so the write is silently dropped.
  always_comb begin
    w_wr_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ch == CH_W'(i))
        w_wr_ready = w_ch_ready[i];
    end
  end

  assign wr_ready = w_wr_ready;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed bench for multi_channel_clock_divider with DEFAULT_DIV=4, three channels.
module tb_multi_channel_clock_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ch_en = '0;
  logic       sync_restart = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_div = '0;
  logic [2:0] tick;
  logic [2:0] div_clk;

  int errors = 0;
  int checks = 0;
  logic       s_rdy;
  logic [2:0] s_tk;
  logic [2:0] s_dc;

  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic [7:0] d;
    logic       rdy;
    logic [2:0] tk;
    logic [2:0] dc;
  } vec_t;

  vec_t tbl [12];

  multi_channel_clock_divider #(
    .NUM_CH      (3),
    .CNT_W       (8),
    .DEFAULT_DIV (4),
    .CH_W        (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_en        (ch_en),
    .sync_restart (sync_restart),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_ch        (wr_ch),
    .wr_div       (wr_div),
    .tick         (tick),
    .div_clk      (div_clk)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample ready before the edge, outputs after it.
  task automatic step(input logic [2:0] en, input logic rs, input logic v,
                      input logic [1:0] ch, input logic [7:0] d);
    @(negedge clk);
    ch_en = en; sync_restart = rs; wr_valid = v; wr_ch = ch; wr_div = d;
    #1 s_rdy = wr_ready;
    @(posedge clk);
    #1;
    s_tk = tick;
    s_dc = div_clk;
  endtask

  task automatic run_default(input string tag);
    for (int k = 1; k <= 10; k++) begin
      step(3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
      chk({tag, "_tick"}, 8'(s_tk), (k % 5 == 0) ? 8'h7 : 8'h0);
      chk({tag, "_dclk"}, 8'(s_dc), (((k / 5) % 2) == 1) ? 8'h7 : 8'h0);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000};
    tbl[1]  = '{1'b1, 2'd1, 8'd1, 1'b1, 3'b000, 3'b000};
    tbl[2]  = '{1'b1, 2'd1, 8'd1, 1'b0, 3'b000, 3'b000};
    tbl[3]  = '{1'b1, 2'd1, 8'd1, 1'b0, 3'b000, 3'b000};
    tbl[4]  = '{1'b1, 2'd1, 8'd1, 1'b0, 3'b111, 3'b111};
    tbl[5]  = '{1'b1, 2'd1, 8'd1, 1'b1, 3'b000, 3'b111};
    tbl[6]  = '{1'b0, 2'd1, 8'd0, 1'b0, 3'b010, 3'b101};
    tbl[7]  = '{1'b1, 2'd3, 8'd0, 1'b1, 3'b000, 3'b101};
    tbl[8]  = '{1'b0, 2'd0, 8'd0, 1'b1, 3'b010, 3'b111};
    tbl[9]  = '{1'b0, 2'd0, 8'd0, 1'b1, 3'b101, 3'b010};
    tbl[10] = '{1'b0, 2'd0, 8'd0, 1'b1, 3'b010, 3'b000};
    tbl[11] = '{1'b0, 2'd0, 8'd0, 1'b1, 3'b000, 3'b000};

    // Reset state
    #12;
    chk("rst_tick", 8'(tick), 8'h0);
    chk("rst_dclk", 8'(div_clk), 8'h0);
    chk("rst_ready", 8'(wr_ready), 8'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Cycles 1..10 at default divisor 4
    run_default("def");

    // Cycles 11..22: ch1 reprogrammed to 1, held second write, dropped out-of-range write
    for (int i = 0; i < 12; i++) begin
      step(3'b111, 1'b0, tbl[i].v, tbl[i].ch, tbl[i].d);
      chk($sformatf("wr_ready_c%0d", i + 11), 8'(s_rdy), 8'(tbl[i].rdy));
      chk($sformatf("wr_tick_c%0d", i + 11), 8'(s_tk), 8'(tbl[i].tk));
      chk($sformatf("wr_dclk_c%0d", i + 11), 8'(s_dc), 8'(tbl[i].dc));
    end

    // Cycle 23: ch2 divisor 0, applied at its terminal count in cycle 25
    step(3'b111, 1'b0, 1'b1, 2'd2, 8'd0);
    chk("div0_wr_ready", 8'(s_rdy), 8'h1);
    for (int k = 24; k <= 35; k++) begin
      step(3'b111, 1'b0, 1'b0, 2'd2, 8'd0);
      chk($sformatf("div0_ready_c%0d", k), 8'(s_rdy), (k >= 26) ? 8'h1 : 8'h0);
      if (k >= 25) begin
        chk($sformatf("div0_tick_c%0d", k), 8'(s_tk[2]), 8'h1);
        chk($sformatf("div0_dclk_c%0d", k), 8'(s_dc[2]), 8'(k % 2));
      end
    end

    // ch0 -> 2, ch1 -> 4 pending, then restart with a direct write of 1 to ch2
    step(3'b111, 1'b0, 1'b1, 2'd0, 8'd2);
    chk("rs_wr0_ready", 8'(s_rdy), 8'h1);
    step(3'b111, 1'b0, 1'b1, 2'd1, 8'd4);
    chk("rs_wr1_ready", 8'(s_rdy), 8'h1);
    step(3'b111, 1'b1, 1'b1, 2'd2, 8'd1);
    chk("rs_wr2_ready", 8'(s_rdy), 8'h1);
    chk("rs_tick", 8'(s_tk), 8'h0);
    chk("rs_dclk", 8'(s_dc), 8'h0);
    for (int j = 1; j <= 35; j++) begin
      step(3'b111, 1'b0, 1'b0, 2'd2, 8'd0);
      if (j == 1) chk("rs_ch2_ready", 8'(s_rdy), 8'h1);
      chk($sformatf("rs_tick_j%0d", j), 8'(s_tk),
          8'({(j % 2 == 0), (j % 5 == 0), (j % 3 == 0)}));
      chk($sformatf("rs_dclk_j%0d", j), 8'(s_dc),
          8'({((j / 2) % 2 == 1), ((j / 5) % 2 == 1), ((j / 3) % 2 == 1)}));
    end

    // Disable ch0 while div_clk[0] is high, then re-enable
    for (int k = 0; k < 3; k++) begin
      step(3'b110, 1'b0, 1'b0, 2'd0, 8'd0);
      chk($sformatf("dis_tick0_%0d", k), 8'(s_tk[0]), 8'h0);
      chk($sformatf("dis_dclk0_%0d", k), 8'(s_dc[0]), 8'h0);
    end
    for (int r = 1; r <= 3; r++) begin
      step(3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
      chk($sformatf("reen_tick0_r%0d", r), 8'(s_tk[0]), (r == 3) ? 8'h1 : 8'h0);
      chk($sformatf("reen_dclk0_r%0d", r), 8'(s_dc[0]), (r == 3) ? 8'h1 : 8'h0);
    end

    // Asynchronous reset between clock edges
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tick", 8'(tick), 8'h0);
    chk("arst_dclk", 8'(div_clk), 8'h0);
    chk("arst_ready", 8'(wr_ready), 8'h1);
    ch_en = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    run_default("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_clock_divider.md
Name: multi_channel_clock_divider

Overview:
- Parametrised successor to the single fixed-count LED timing divider.
- Generates NUM_CH independent divided clocks (50% toggle outputs) plus single-cycle tick strobes from one system clock.
- Each channel's divisor is programmable at run time through a valid/ready write port, and updates are applied glitch-free at terminal count.
- Sits between the board clock and the WS2812B bit/frame timing logic, which consumes the ticks as clock enables.

Parameters:
- NUM_CH, 3: number of independent divider channels (1..16).
- CNT_W, 24: counter and divisor width in bits.
- DEFAULT_DIV, 2400000: divisor loaded into every channel at reset (must fit in CNT_W).
- CH_W, 2: width of the channel select, equal to clog2(NUM_CH), minimum 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync_restart  in  1  one-cycle pulse; phase-aligns all channels.
- wr_valid  in  1  divisor write request.
- wr_ready  out  1  divisor write accepted when high with wr_valid.
- wr_ch  in  CH_W  target channel of the write.
- wr_div  in  CNT_W  new terminal count for that channel.
- tick  out  NUM_CH  one-cycle strobe per channel at terminal count.
- div_clk  out  NUM_CH  divided clock per channel, toggles at terminal count.

Behaviour:
- Per-channel state: cnt, div (active terminal count), pend_div, pend_flag.
- Reset (rst_n low, asynchronous):
  - cnt = 0, div = DEFAULT_DIV, pend_flag = 0.
  - tick = 0, div_clk = 0.
- Counting (channel enabled, no restart):
  - If cnt == div: cnt <= 0, tick <= 1, div_clk <= ~div_clk.
  - Otherwise: cnt <= cnt + 1, tick <= 0.
  - Tick period is div+1 cycles; div_clk period is 2*(div+1) cycles.
  - tick and div_clk are registered, one cycle after cnt reaches div.
- div == 0: tick stays high continuously and div_clk toggles every cycle.
- Counter arithmetic is unsigned CNT_W. cnt never exceeds div, so no wrap occurs. If div is lowered below a running cnt, the new value only takes effect at terminal count (see below), so this case cannot arise.
- Channel disabled (ch_en[i] = 0): cnt <= 0, tick <= 0, div_clk <= 0. A pending divisor is applied immediately.
- Re-enable: counting resumes from 0. The first tick comes div+1 cycles after ch_en rises.
- Write handshake:
  - wr_ready = ~pend_flag[wr_ch], combinational from registered state.
  - A transfer occurs when wr_valid & wr_ready.
  - On transfer: pend_div[wr_ch] <= wr_div, pend_flag[wr_ch] <= 1.
  - When wr_ch >= NUM_CH: wr_ready = 1 and the write is dropped.
- Apply:
  - At the cycle cnt == div with pend_flag set: div <= pend_div, pend_flag <= 0.
  - The current period completes with the old divisor, so there is no runt pulse.
  - A write arriving in the same cycle as an apply sees wr_ready = 0 and is held off one cycle.
- sync_restart:
  - All cnt <= 0, all div_clk <= 0, all tick <= 0.
  - All pending divisors apply immediately.
  - sync_restart overrides terminal count in the same cycle.
  - A write transferred in the restart cycle loads div directly and leaves pend_flag = 0.
- rst_n asserted mid-period: outputs go low asynchronously and all divisors revert to DEFAULT_DIV.
- Channels never interact except through sync_restart.

Decomposition:
- Package divider_pkg: DEFAULT_DIV, CNT_W, and a localparam function for clog2 used to derive CH_W.
- One natural sub-module, divider_channel, instantiated NUM_CH times via generate. It holds cnt, div, pend_div, pend_flag and the outputs.
- The top level does wr_ch decode, the wr_ready mux and sync_restart fan-out.

Test Plan:
- Reset with DEFAULT_DIV overridden to 4, ch_en = 3'b111 -> each tick high every 5 cycles; div_clk period 10 cycles, first rise 5 cycles after ch_en high.
- Write wr_ch = 1, wr_div = 1 mid-period -> ch1 finishes its current 5-cycle period, then ticks every 2 cycles. wr_ready for ch1 is low from transfer until the apply cycle. ch0 and ch2 are unchanged.
- Second write to ch1 while pending -> wr_ready = 0 and wr_valid is held. The write is accepted the cycle after the apply.
- wr_div = 0 on ch2 -> tick[2] constantly 1 and div_clk[2] toggling every cycle.
- Channels at divisors 2 and 4, pulse sync_restart -> both div_clk low next cycle. The first ticks arrive at 3 and 5 cycles, and the rising edges coincide every 30 cycles.
- Deassert ch_en[0] mid-count -> tick[0] = 0 and div_clk[0] = 0 next cycle. Assert rst_n = 0 asynchronously mid-run -> all outputs 0 immediately and divisors revert to default.
